hash_msg_feeder: RTL

HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

---
 rtl/hash_feeder_pkg.sv | 18 +
 rtl/hash_msg_feeder_if.sv | 41 ++++
 rtl/hash_feeder_fifo.sv | 57 +++++
 rtl/hash_msg_feeder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/hash_feeder_pkg.sv
// Shared types and constants for the hash message feeder.
// Optional feature macro: HASH_FEEDER_CHECK_EN (expected-digest compare).
package hash_feeder_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int BYTE_W     = 8;
  localparam int LEN_W      = 64;
  localparam int DIG_W      = 32;

  // Feeder control states; encoding 2'd3 is illegal and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/hash_msg_feeder_if.sv
// Bus bundle between the host side, the feeder and the hash core.
// Handshake rule for cmd_* and wr_*: a transfer happens on a rising clk edge
// where valid && ready are both high; valid may be raised independently of
// ready, and payload must be stable while valid is high and ready is low.
interface hash_msg_feeder_if;
  import hash_feeder_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DIG_W-1:0]  exp_digest;
  logic              wr_valid;
  logic              wr_ready;
  logic [BYTE_W-1:0] wr_data;
  logic              m_valid;
  logic [BYTE_W-1:0] message;
  logic [LEN_W-1:0]  counter;
  logic              hash_ready;
  logic [DIG_W-1:0]  digest_in;
  logic [DIG_W-1:0]  digest_out;
  logic              digest_valid;
  logic              digest_match;
  logic              busy;

  // Feeder view.
  modport slave (
    input  cmd_valid, cmd_len, exp_digest, wr_valid, wr_data,
           hash_ready, digest_in,
    output cmd_ready, wr_ready, m_valid, message, counter,
           digest_out, digest_valid, digest_match, busy
  );

  // Host plus hash-core view.
  modport master (
    output cmd_valid, cmd_len, exp_digest, wr_valid, wr_data,
           hash_ready, digest_in,
    input  cmd_ready, wr_ready, m_valid, message, counter,
           digest_out, digest_valid, digest_match, busy
  );

endinterface

// File: rtl/hash_feeder_fifo.sv
// Byte FIFO, FIFO_DEPTH entries, with full/empty flags.
// Push while full is dropped; push and pop in the same cycle both apply.
module hash_feeder_fifo
  import hash_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [BYTE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full_o    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because count_q gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// Hash message feeder: buffers message bytes, streams exactly cmd_len of
// them to a hash core one per cycle, then waits for a fresh hash_ready edge
// to capture the digest.
// Optional feature macro: HASH_FEEDER_CHECK_EN -- latches exp_digest on the
// command handshake and reports digest_match; without it digest_match is 0.
module hash_msg_feeder
  import hash_feeder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  hash_msg_feeder_if.slave       bus,
  output state_t                 state_o
);

  state_t            state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  counter_q;
  logic              m_valid_q;
  logic [BYTE_W-1:0] message_q;
  logic [DIG_W-1:0]  digest_out_q;
  logic              digest_valid_q;
  logic              hash_ready_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              push;
  logic              pop;
  logic              cmd_fire;
  logic              hash_rise;

  // Bytes are accepted in every state; the FIFO only refuses when full.
  assign push      = bus.wr_valid && !fifo_full;
  // One byte per cycle while the current message still needs bytes.
  assign pop       = (state_q == S_STREAM) && (remaining_q != '0) && !fifo_empty;
  assign cmd_fire  = bus.cmd_valid && (state_q == S_IDLE);
  // Only a fresh 0->1 transition of the core's done level counts.
  assign hash_rise = bus.hash_ready && !hash_ready_q;

  hash_feeder_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (bus.wr_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef HASH_FEEDER_CHECK_EN
  logic [DIG_W-1:0] exp_q;
  logic             digest_match_q;

  // Expected digest travels with the command that introduced it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (cmd_fire) begin
      exp_q <= bus.exp_digest;
    end
  end

  // Match flag is refreshed only when a new digest is captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digest_match_q <= 1'b0;
    end else if ((state_q == S_WAIT) && hash_rise) begin
      digest_match_q <= (bus.digest_in == exp_q);
    end
  end

  assign bus.digest_match = digest_match_q;
`else
  logic unused_exp_digest;
  assign unused_exp_digest = ^bus.exp_digest;
  assign bus.digest_match  = 1'b0;
`endif

  // Control FSM with registered stream and digest outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      counter_q      <= '0;
      m_valid_q      <= 1'b0;
      message_q      <= '0;
      digest_out_q   <= '0;
      digest_valid_q <= 1'b0;
      hash_ready_q   <= 1'b0;
    end else begin
      m_valid_q      <= 1'b0;
      digest_valid_q <= 1'b0;
      hash_ready_q   <= bus.hash_ready;
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            remaining_q <= bus.cmd_len;
            counter_q   <= bus.cmd_len;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (remaining_q == '0) begin
            // Empty message: the core still needs one strobe to start.
            m_valid_q <= 1'b1;
            message_q <= '0;
            state_q   <= S_WAIT;
          end else if (!fifo_empty) begin
            m_valid_q   <= 1'b1;
            message_q   <= fifo_rd_data;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (hash_rise) begin
            digest_out_q   <= bus.digest_in;
            digest_valid_q <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.wr_ready     = !fifo_full;
  assign bus.m_valid      = m_valid_q;
  assign bus.message      = message_q;
  assign bus.counter      = counter_q;
  assign bus.digest_out   = digest_out_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign state_o          = state_q;

endmodule
